// File: rtl/slice_sweep_sched.sv
// Time-multiplexed sweep over every legal (inner_left, inner_right, offset) slice tuple
// of an outer array, issuing xs=1..2^W-1 per tuple over valid/ready. Optional: SWEEP_ABORT_EN.
module slice_sweep_sched #(
    parameter int BASE = 0,
    parameter int SIZE = 4,
    parameter int DIR  = 1,
    parameter int W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   step_valid,
    input  logic                   step_ready,
    output logic signed [7:0]      inner_left,
    output logic signed [7:0]      inner_right,
    output logic signed [7:0]      offset,
    output logic [W-1:0]           xs,
    output logic [SIZE-1:0]        sel_mask
`ifdef SWEEP_ABORT_EN
    , input  logic                 abort
    , output logic                 aborted
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int LAST_I = BASE + DIR * (SIZE - 1);
    localparam int LO_I   = (BASE < LAST_I) ? BASE : LAST_I;
    localparam int HI_I   = (BASE < LAST_I) ? LAST_I : BASE;
    localparam logic signed [7:0] LO = 8'(LO_I);
    localparam logic signed [7:0] HI = 8'(HI_I);
    localparam logic [W-1:0] XS_MAX = {W{1'b1}};
    localparam logic [W-1:0] XS_ONE = W'(1);

    state_t             state_r, state_n;
    logic signed [7:0]  il_r, ir_r, off_r;
    logic signed [7:0]  nxt_il_s, nxt_ir_s, nxt_off_s;
    logic signed [7:0]  mn_s, mx_s;
    logic [W-1:0]       xs_r;
    logic               busy_r, done_r, valid_r, tuple_vld_r;
    logic               last_tuple_s;
    logic               abort_s;
    logic [SIZE-1:0]    sel_mask_s;

`ifdef SWEEP_ABORT_EN
    logic               aborted_r;
    assign abort_s = abort;
    assign aborted = aborted_r;
`else
    assign abort_s = 1'b0;
`endif

    function automatic logic signed [7:0] elem_idx(input int k);
        return 8'(BASE + DIR * k);
    endfunction

    // Successor of the current tuple in (l, r, offset) order, skipping illegal (l, r) pairs.
    always_comb begin
        nxt_il_s     = il_r;
        nxt_ir_s     = ir_r;
        nxt_off_s    = off_r;
        last_tuple_s = 1'b0;
        if (off_r != 8'sd2) begin
            nxt_off_s = off_r + 8'sd1;
        end else begin
            nxt_off_s = -8'sd2;
            if (DIR > 0) begin
                // Ascending: legal r runs l..HI, so the next row starts on the diagonal.
                if (ir_r != HI) begin
                    nxt_ir_s = ir_r + 8'sd1;
                end else if (il_r != HI) begin
                    nxt_il_s = il_r + 8'sd1;
                    nxt_ir_s = il_r + 8'sd1;
                end else begin
                    last_tuple_s = 1'b1;
                end
            end else begin
                // Descending: legal r runs LO..l.
                if (ir_r != il_r) begin
                    nxt_ir_s = ir_r + 8'sd1;
                end else if (il_r != HI) begin
                    nxt_il_s = il_r + 8'sd1;
                    nxt_ir_s = LO;
                end else begin
                    last_tuple_s = 1'b1;
                end
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_n = RUN;
                else       state_n = IDLE;
            end
            RUN: begin
                if (abort_s)                             state_n = IDLE;
                else if (step_ready && (xs_r == XS_MAX)) state_n = ADV;
                else                                     state_n = RUN;
            end
            ADV: begin
                if (abort_s)           state_n = IDLE;
                else if (last_tuple_s) state_n = FIN;
                else                   state_n = RUN;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, status flags and the tuple/xs registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            il_r        <= 8'sd0;
            ir_r        <= 8'sd0;
            off_r       <= 8'sd0;
            xs_r        <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            valid_r     <= 1'b0;
            tuple_vld_r <= 1'b0;
`ifdef SWEEP_ABORT_EN
            aborted_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n == RUN) || (state_n == ADV);
            valid_r <= (state_n == RUN);
            done_r  <= (state_n == FIN);
`ifdef SWEEP_ABORT_EN
            aborted_r <= abort_s && ((state_r == RUN) || (state_r == ADV));
`endif
            case (state_r)
                IDLE: begin
                    if (start) begin
                        il_r        <= LO;
                        ir_r        <= LO;
                        off_r       <= -8'sd2;
                        xs_r        <= XS_ONE;
                        tuple_vld_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (step_ready && (xs_r != XS_MAX)) xs_r <= xs_r + XS_ONE;
                end
                ADV: begin
                    if (!abort_s && !last_tuple_s) begin
                        il_r  <= nxt_il_s;
                        ir_r  <= nxt_ir_s;
                        off_r <= nxt_off_s;
                        xs_r  <= XS_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Span bounds of the current slice.
    always_comb begin
        if (il_r < ir_r) begin
            mn_s = il_r;
            mx_s = ir_r;
        end else begin
            mn_s = ir_r;
            mx_s = il_r;
        end
    end

    // Element k is selected when its offset index lands inside the slice span.
    always_comb begin
        sel_mask_s = '0;
        for (int k = 0; k < SIZE; k++) begin
            sel_mask_s[k] = tuple_vld_r
                          && ((elem_idx(k) + off_r) >= mn_s)
                          && ((elem_idx(k) + off_r) <= mx_s);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign step_valid  = valid_r;
    assign inner_left  = il_r;
    assign inner_right = ir_r;
    assign offset      = off_r;
    assign xs          = xs_r;
    assign sel_mask    = sel_mask_s;

endmodule

// File: tb/tb_slice_sweep_sched.sv
// Bench for slice_sweep_sched: an ascending and a descending instance share stimulus;
// handshakes are scored against a nested-loop model built from the slice legality rules.
module tb_slice_sweep_sched;
    localparam int W    = 2;
    localparam int SIZE = 2;
    localparam int BASE = 0;

    logic clk = 1'b0;
    logic rst_n, start, step_ready;
    logic busy1, done1, v1, busy2, done2, v2;
    logic signed [7:0] il1, ir1, off1, il2, ir2, off2;
    logic [W-1:0] xs1, xs2;
    logic [SIZE-1:0] m1, m2;
`ifdef SWEEP_ABORT_EN
    logic abort, aborted1, aborted2;
`endif

    slice_sweep_sched #(.BASE(BASE), .SIZE(SIZE), .DIR(1), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
        .step_valid(v1), .step_ready(step_ready), .inner_left(il1), .inner_right(ir1),
        .offset(off1), .xs(xs1), .sel_mask(m1)
`ifdef SWEEP_ABORT_EN
        , .abort(abort), .aborted(aborted1)
`endif
    );

    slice_sweep_sched #(.BASE(BASE), .SIZE(SIZE), .DIR(-1), .W(W)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .done(done2),
        .step_valid(v2), .step_ready(step_ready), .inner_left(il2), .inner_right(ir2),
        .offset(off2), .xs(xs2), .sel_mask(m2)
`ifdef SWEEP_ABORT_EN
        , .abort(abort), .aborted(aborted2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      il, ir, off;
        logic [W-1:0]    xs;
        logic [SIZE-1:0] m;
    } step_t;

    typedef struct {
        logic            ready;
        logic            v;
        logic [7:0]      il, ir, off;
        logic [W-1:0]    xs;
        logic [SIZE-1:0] m;
    } vec_t;

    int checks = 0;
    int failures = 0;
    step_t q1[$];
    step_t q2[$];
    bit mon_en = 1'b0;
    int dn1 = 0;
    int dn2 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic v, input logic [7:0] il, input logic [7:0] ir,
                                       input logic [7:0] off, input logic [W-1:0] x,
                                       input logic [SIZE-1:0] m);
        return {23'd0, v, il, ir, off, 8'(x), 8'(m)};
    endfunction

    // Reference: every (l, r, offset, xs) in loop order, keeping only pairs with (l-r)*dir <= 0.
    task automatic build_model(input int which, input int dir);
        int last, lo, hi, smin, smax, pos;
        step_t s;
        last = BASE + dir * (SIZE - 1);
        lo = (BASE < last) ? BASE : last;
        hi = (BASE < last) ? last : BASE;
        if (which == 1) q1.delete(); else q2.delete();
        for (int l = lo; l <= hi; l++) begin
            for (int r = lo; r <= hi; r++) begin
                if ((l - r) * dir <= 0) begin
                    for (int o = -2; o <= 2; o++) begin
                        for (int x = 1; x < (1 << W); x++) begin
                            smin = (l < r) ? l : r;
                            smax = (l < r) ? r : l;
                            s.il = 8'(l); s.ir = 8'(r); s.off = 8'(o); s.xs = W'(x);
                            for (int k = 0; k < SIZE; k++) begin
                                pos = BASE + dir * k + o;
                                s.m[k] = (pos >= smin) && (pos <= smax);
                            end
                            if (which == 1) q1.push_back(s); else q2.push_back(s);
                        end
                    end
                end
            end
        end
    endtask

    // Handshake scoreboard and done counters.
    always @(negedge clk) begin
        step_t e;
        if (mon_en && rst_n && step_ready && v1) begin
            if (q1.size() == 0) check("sb1_extra_step", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                check("sb1_step", pk(1'b1, il1, ir1, off1, xs1, m1), pk(1'b1, e.il, e.ir, e.off, e.xs, e.m));
            end
        end
        if (mon_en && rst_n && step_ready && v2) begin
            if (q2.size() == 0) check("sb2_extra_step", 64'd1, 64'd0);
            else begin
                e = q2.pop_front();
                check("sb2_step", pk(1'b1, il2, ir2, off2, xs2, m2), pk(1'b1, e.il, e.ir, e.off, e.xs, e.m));
            end
        end
        if (mon_en && done1) dn1++;
        if (mon_en && done2) dn2++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; step_ready = 1'b0;
`ifdef SWEEP_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        check("rst1_fields", pk(v1, il1, ir1, off1, xs1, m1), 64'd0);
        check("rst2_fields", pk(v2, il2, ir2, off2, xs2, m2), 64'd0);
        check("rst_ctl", 64'({busy1, done1, busy2, done2}), 64'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advance with ready=1 until n handshakes of the ascending instance are queued.
    task automatic run_steps(input int n, input string name);
        int cnt, cyc;
        cnt = 0; cyc = 0;
        step_ready = 1'b1;
        while (cnt < n && cyc < 200) begin
            if (v1) cnt++;
            if (cnt < n) tick();
            cyc++;
        end
        check(name, 64'(cnt), 64'(n));
    endtask

    task automatic random_sweep(input string name);
        int cyc;
        bit seen;
        build_model(1, 1);
        build_model(2, -1);
        dn1 = 0; dn2 = 0; cyc = 0; seen = 1'b0;
        mon_en = 1'b1;
        step_ready = 1'b1;
        do_start();
        while (!seen && cyc < 2000) begin
            step_ready = ($urandom_range(0, 3) != 0);
            if (done1) begin
                start = 1'b1;
                seen = 1'b1;
            end else if (busy1) start = ($urandom_range(0, 5) == 0);
            else start = 1'b0;
            tick();
            cyc++;
        end
        start = 1'b0;
        check({name, "_timeout"}, 64'(seen), 64'd1);
        repeat (6) tick();
        check({name, "_idle"}, 64'({busy1, busy2, v1, v2}), 64'd0);
        check({name, "_q_left"}, 64'(q1.size() + q2.size()), 64'd0);
        check({name, "_done1"}, 64'(dn1), 64'd1);
        check({name, "_done2"}, 64'(dn2), 64'd1);
        mon_en = 1'b0;
    endtask

    initial begin
        vec_t tbl[10];
        tbl[0] = '{1'b1, 1'b1, 8'd0, 8'd0, 8'hFE, 2'd1, 2'b00};
        tbl[1] = '{1'b0, 1'b1, 8'd0, 8'd0, 8'hFE, 2'd2, 2'b00};
        tbl[2] = '{1'b1, 1'b1, 8'd0, 8'd0, 8'hFE, 2'd2, 2'b00};
        tbl[3] = '{1'b1, 1'b1, 8'd0, 8'd0, 8'hFE, 2'd3, 2'b00};
        tbl[4] = '{1'b1, 1'b0, 8'd0, 8'd0, 8'hFE, 2'd3, 2'b00};
        tbl[5] = '{1'b1, 1'b1, 8'd0, 8'd0, 8'hFF, 2'd1, 2'b10};
        tbl[6] = '{1'b1, 1'b1, 8'd0, 8'd0, 8'hFF, 2'd2, 2'b10};
        tbl[7] = '{1'b1, 1'b1, 8'd0, 8'd0, 8'hFF, 2'd3, 2'b10};
        tbl[8] = '{1'b1, 1'b0, 8'd0, 8'd0, 8'hFF, 2'd3, 2'b10};
        tbl[9] = '{1'b1, 1'b1, 8'd0, 8'd0, 8'd0,  2'd1, 2'b01};

        do_reset();
        do_start();
        for (int i = 0; i < 10; i++) begin
            step_ready = tbl[i].ready;
            check($sformatf("tbl_row%0d", i), pk(v1, il1, ir1, off1, xs1, m1),
                  pk(tbl[i].v, tbl[i].il, tbl[i].ir, tbl[i].off, tbl[i].xs, tbl[i].m));
            tick();
        end

        // Backpressure holds every field.
        do_reset();
        do_start();
        step_ready = 1'b1;
        tick();
        step_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", pk(v1, il1, ir1, off1, xs1, m1), pk(1'b1, 8'd0, 8'd0, 8'hFE, 2'd2, 2'b00));
            tick();
        end
        step_ready = 1'b1;
        check("stall_release", 64'(xs1), 64'd2);
        tick();
        check("stall_step", pk(v1, il1, ir1, off1, xs1, m1), pk(1'b1, 8'd0, 8'd0, 8'hFE, 2'd3, 2'b00));
        tick();
        check("stall_adv", 64'({v1, busy1}), 64'b01);

        do_reset();
        random_sweep("sweep_a");
        random_sweep("sweep_b");

        // Reset mid-sweep, then restart from the first tuple; start while busy is ignored.
        do_reset();
        do_start();
        run_steps(20, "t5_reach20");
        rst_n = 1'b0;
        tick();
        check("t5_rst_fields", pk(v1, il1, ir1, off1, xs1, m1), 64'd0);
        check("t5_rst_ctl", 64'({busy1, done1, busy2}), 64'd0);
        rst_n = 1'b1;
        tick();
        check("t5_idle", 64'({busy1, v1}), 64'd0);
        do_start();
        check("t5_first1", pk(v1, il1, ir1, off1, xs1, m1), pk(1'b1, 8'd0, 8'd0, 8'hFE, 2'd1, 2'b00));
        check("t5_first2", pk(v2, il2, ir2, off2, xs2, m2), pk(1'b1, 8'hFF, 8'hFF, 8'hFE, 2'd1, 2'b00));
        step_ready = 1'b1;
        start = 1'b1;
        tick();
        check("t5_busy_start_a", 64'(xs1), 64'd2);
        tick();
        check("t5_busy_start_b", 64'(xs1), 64'd3);
        start = 1'b0;

`ifdef SWEEP_ABORT_EN
        do_reset();
        do_start();
        run_steps(7, "t6_reach7");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_aborted", 64'({aborted1, aborted2, busy1, v1, done1}), 64'b11000);
        tick();
        check("t6_pulse_end", 64'({aborted1, aborted2}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("t6_no_done", 64'({done1, busy1}), 64'd0);
            tick();
        end
        random_sweep("t6_sweep");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
